// File: rtl/rv64_mem_pkg.sv
// Shared types and helpers for the RV64 load/store memory port.
package rv64_mem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } mem_funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Access size in bytes (1, 2, 4 or 8) from funct3[1:0].
    function automatic logic [3:0] mem_size(input logic [2:0] funct3);
        return 4'(4'd1 << funct3[1:0]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load extraction/extension and store byte-merge over one RAM window.
module lsu_align
    import rv64_mem_pkg::*;
#(
    parameter int unsigned M = 64
) (
    input  logic [M-1:0] window,
    input  logic [M-1:0] wdata,
    input  logic [2:0]   funct3,
    output logic [M-1:0] load_data,
    output logic [M-1:0] store_window
);

    logic [3:0] size;
    assign size = mem_size(funct3);

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = M'($signed(window[7:0]));
            F3_H:    load_data = M'($signed(window[15:0]));
            F3_W:    load_data = M'($signed(window[31:0]));
            F3_D:    load_data = window;
            F3_BU:   load_data = M'(window[7:0]);
            F3_HU:   load_data = M'(window[15:0]);
            F3_WU:   load_data = M'(window[31:0]);
            default: load_data = '0;
        endcase
    end

    // Low size bytes from the store data, the rest written back as read.
    always_comb begin
        store_window = window;
        for (int unsigned i = 0; i < M / 8; i++) begin
            if (i < 32'(size)) begin
                store_window[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU memory port: one request at a time, access checks, RMW for narrow stores.
module lsu_mem_port
    import rv64_mem_pkg::*;
#(
    parameter int unsigned N = 13,
    parameter int unsigned M = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [63:0]   req_addr,
    input  logic [M-1:0]  req_wdata,
    output logic          resp_valid,
    output logic [M-1:0]  resp_rdata,
    output logic          resp_err,
    output logic          mem_we,
    output logic [N-1:0]  mem_addr,
    output logic [M-1:0]  mem_wdata,
    input  logic [M-1:0]  mem_rdata
);

    lsu_state_e   state;
    logic [2:0]   funct3_q;
    logic         we_q;
    logic         err_q;
    logic [M-1:0] wdata_q;
    logic [M-1:0] win_q;
    logic         mem_we_q;

    logic         accept;
    logic         bad_f3;
    logic         req_err;
    logic [N:0]   end_addr;
    logic [M-1:0] align_win;
    logic [M-1:0] load_data;
    logic [M-1:0] store_window;

    assign accept   = req_valid && req_ready;
    assign end_addr = {1'b0, req_addr[N-1:0]} + (N+1)'(mem_size(req_funct3));

    always_comb begin
        bad_f3  = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        req_err = (req_addr[63:N] != '0) || (end_addr > {1'b1, {N{1'b0}}}) || bad_f3;
    end

    // Merge against live RAM data in RD; extract loads from the buffer in RESP.
    assign align_win = (state == RD) ? mem_rdata : win_q;

    lsu_align #(.M(M)) u_align (
        .window       (align_win),
        .wdata        (wdata_q),
        .funct3       (funct3_q),
        .load_data    (load_data),
        .store_window (store_window)
    );

    // Reset must be able to kill a write already in flight.
    assign mem_we = mem_we_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            win_q      <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                end
                RD: begin
                    win_q <= mem_rdata;
                    if (we_q) begin
                        state     <= WR;
                        req_ready <= 1'b0;
                        mem_we_q  <= 1'b1;
                        mem_wdata <= store_window;
                    end else begin
                        state     <= RESP;
                        req_ready <= 1'b1;
                    end
                end
                WR: begin
                    state     <= RESP;
                    req_ready <= 1'b1;
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= (err_q || we_q) ? '0 : load_data;
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            // A new request may overlap the response cycle of the previous one.
            if (accept) begin
                funct3_q  <= req_funct3;
                we_q      <= req_we;
                err_q     <= req_err;
                wdata_q   <= req_wdata;
                mem_addr  <= req_addr[N-1:0];
                mem_wdata <= req_wdata;
                state     <= req_err ? RESP : RD;
                req_ready <= req_err;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a byte-addressed RAM model.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [7:0]  ram [0:8191];
    logic        pre_load;

    int total = 0;
    int bad   = 0;

    lsu_mem_port #(.N(13), .M(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM: combinational read window, full-window write, wraps modulo 2^13.
    always_comb begin
        for (int i = 0; i < 8; i++) mem_rdata[i*8 +: 8] = ram[13'(int'(mem_addr) + i)];
    end

    always @(posedge clk) begin
        if (pre_load) begin
            for (int i = 0; i < 8; i++) begin
                ram[13'(32'h1000 + i)] <= 8'(17 * (i + 1));
                ram[13'(32'h1FF8 + i)] <= 8'(32'hF0 + i);
                ram[13'(i)]            <= 8'(32'h30 + i);
            end
            ram[13'h1008] <= 8'hA5;
            ram[13'h1009] <= 8'h5A;
        end else if (mem_we) begin
            for (int i = 0; i < 8; i++) ram[13'(int'(mem_addr) + i)] <= mem_wdata[i*8 +: 8];
        end
    end

    function automatic logic [63:0] ram64(input int a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = ram[13'(a + i)];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk);
        pre_load = 1'b1;
        @(negedge clk);
        pre_load = 1'b0;
    endtask

    // Issue one request; lat counts negedges after the accept edge until resp_valid.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, output int lat, output logic [63:0] rd,
                           output logic er, output int wes);
        lat = -1; rd = '0; er = 1'b0; wes = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_we) wes++;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] exp);
        int lat, wes;
        logic [63:0] rd;
        logic er;
        run_req(1'b0, f3, addr, '0, lat, rd, er, wes);
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, 64'(er), 64'd0);
        check({tag, "_we"}, 64'(wes), 64'd0);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [63:0] addr);
        int lat, wes;
        logic [63:0] rd;
        logic er;
        run_req(we, f3, addr, 64'hDEADBEEF00C0FFEE, lat, rd, er, wes);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check({tag, "_err"}, 64'(er), 64'd1);
        check({tag, "_data"}, rd, 64'd0);
        check({tag, "_we"}, 64'(wes), 64'd0);
        check({tag, "_ram1000"}, ram64(32'h1000), 64'h8877665544332211);
        check({tag, "_ram1ff8"}, ram64(32'h1FF8), 64'hF7F6F5F4F3F2F1F0);
    endtask

    initial begin
        int lat, wes;
        logic [63:0] rd;
        logic er;
        logic [7:0] sh_exp [10];
        logic seen;

        clk = 1'b0; rst = 1'b1; pre_load = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);

        preload();
        do_load("ld_1000",  3'b011, 64'h1000, 64'h8877665544332211);
        do_load("lb_1007",  3'b000, 64'h1007, 64'hFFFFFFFFFFFFFF88);
        do_load("lbu_1007", 3'b100, 64'h1007, 64'h0000000000000088);
        do_load("lw_1004",  3'b010, 64'h1004, 64'hFFFFFFFF88776655);
        do_load("lh_1006",  3'b001, 64'h1006, 64'hFFFFFFFFFFFF8877);
        do_load("lhu_1002", 3'b101, 64'h1002, 64'h0000000000004433);
        do_load("lwu_1004", 3'b110, 64'h1004, 64'h0000000088776655);
        do_load("lb_1000",  3'b000, 64'h1000, 64'h0000000000000011);
        do_load("ld_1ff8",  3'b011, 64'h1FF8, 64'hF7F6F5F4F3F2F1F0);

        // Halfword store into the middle of a window.
        preload();
        run_req(1'b1, 3'b001, 64'h1002, 64'h000000001234ABCD, lat, rd, er, wes);
        check("sh_lat", 64'(lat), 64'd3);
        check("sh_we_cycles", 64'(wes), 64'd1);
        check("sh_data", rd, 64'd0);
        check("sh_err", 64'(er), 64'd0);
        sh_exp = '{8'h11, 8'h22, 8'hCD, 8'hAB, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA5, 8'h5A};
        for (int i = 0; i < 10; i++)
            check($sformatf("sh_byte_%0h", 32'h1000 + i), 64'(ram[13'(32'h1000 + i)]), 64'(sh_exp[i]));

        // Byte store at the top of the array: wrapped window bytes must survive.
        preload();
        run_req(1'b1, 3'b000, 64'h1FFF, 64'h000000000000005C, lat, rd, er, wes);
        check("sb_top_lat", 64'(lat), 64'd3);
        check("sb_top_we_cycles", 64'(wes), 64'd1);
        check("sb_top_hi", ram64(32'h1FF8), 64'h5CF6F5F4F3F2F1F0);
        check("sb_top_wrap", ram64(0), 64'h3736353433323130);

        preload();
        do_err("lw_1ffe", 1'b0, 3'b010, 64'h1FFE);
        do_err("ld_2000", 1'b0, 3'b011, 64'h2000);
        do_err("ld_f3_7", 1'b0, 3'b111, 64'h1000);
        do_err("st_f3_4", 1'b1, 3'b100, 64'h1000);
        do_err("lb_hi",   1'b0, 3'b000, 64'h0000000100001000);
        do_err("sd_1ffc", 1'b1, 3'b011, 64'h1FFC);

        // Reset during the write cycle drops the store.
        preload();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'h1000; req_wdata = 64'hDEADBEEF00C0FFEE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstwr_we_before", 64'(mem_we), 64'd1);
        rst = 1'b1;
        #1;
        check("rstwr_we_gated", 64'(mem_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid || mem_we) seen = 1'b1;
            @(negedge clk);
        end
        check("rstwr_no_resp", 64'(seen), 64'd0);
        check("rstwr_ready", 64'(req_ready), 64'd1);
        check("rstwr_ram", ram64(32'h1000), 64'h8877665544332211);

        // Store followed by a load accepted in the store's response cycle.
        preload();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'h1000; req_wdata = 64'hDEADBEEF00C0FFEE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_rd_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("b2b_wr_we", 64'(mem_we), 64'd1);
        @(negedge clk);
        check("b2b_resp_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h1000; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_sd_valid", 64'(resp_valid), 64'd1);
        check("b2b_sd_data", resp_rdata, 64'd0);
        @(negedge clk);
        check("b2b_gap_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("b2b_ld_valid", 64'(resp_valid), 64'd1);
        check("b2b_ld_data", resp_rdata, 64'hDEADBEEF00C0FFEE);
        check("b2b_ram", ram64(32'h1000), 64'hDEADBEEF00C0FFEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit memory port for the RV64 core. It sits between the execute stage and the byte-addressed unified RAM. It accepts one load or store request at a time, performs size/sign handling for all RV64 load/store widths, and does the read-modify-write that sub-doubleword stores need, because the RAM always writes a full M/8-byte window on `we`. It is the initiator side of the RAM data port: it drives `we`, `data_addr` and `data_in`, and consumes `data_out`.

## Interface
- `N`, 13, RAM address width in bits; the RAM holds 2^N bytes.
- `M`, 64, data width (XLEN); M/8 bytes per RAM window.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request can be accepted this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- `req_addr`  in  64  byte address.
- `req_wdata`  in  M  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  M  load result, extended to M bits; 0 for stores and errors.
- `resp_err`  out  1  access fault; valid only with `resp_valid`.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  N  RAM data address.
- `mem_wdata`  out  M  RAM write data.
- `mem_rdata`  in  M  RAM read data; combinational from `mem_addr`, little-endian.

## Operation
- The FSM has four states: IDLE, RD, WR, RESP.
- A request is accepted when `req_valid && req_ready` at a clock edge. On acceptance the block latches the address, funct3, we and wdata.
- `req_ready` = 1 in IDLE and RESP, and 0 in RD and WR.
- An accepted request is an error when any of the following holds. An error request goes directly to RESP with `resp_err=1` and `resp_rdata=0`, and it never asserts `mem_we`.
  - `req_addr[63:N] != 0`.
  - `req_addr[N-1:0] + size > 2^N`, where size is 1, 2, 4 or 8 bytes.
  - Illegal funct3: 111 for a load, or 1xx for a store.
- A legal request goes to RD.
- RD: `mem_addr` = latched address. The block registers `mem_rdata` into a window buffer.
  - A load then goes to RESP.
  - A store then goes to WR.
- Load extract: take the low size bytes of the window buffer. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU/LD.
- WR: `mem_we=1` for exactly this one cycle. `mem_wdata` is built as follows, then the FSM goes to RESP:
  - Bytes [0, size) come from the latched wdata.
  - Bytes [size, M/8) come from the window buffer.
- RMW window wrap: for a byte at the top of the array, the RAM's window wraps modulo 2^N. Those wrapped bytes are written back with the value just read, so their contents do not change.
- RESP: `resp_valid=1`.
  - If a request is accepted in this cycle, the FSM goes to RD, or to RESP again if the new request is an error.
  - Otherwise the FSM goes to IDLE.
- There is no response backpressure. The consumer must sample `resp_valid` every cycle.

## Timing
- Accept at edge T. Response visible in the cycle after these edges:
  - Error: edge T+1.
  - Load: edge T+2.
  - Store: edge T+3.
- `mem_we` is high only during the cycle between edges T+1 and T+2 of a store.
- Back-to-back accepts in RESP give sustained throughput of one load every 2 cycles or one store every 3 cycles.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. Latches and window buffer are cleared.
- `mem_we` is gated with `!rst`. Reset asserted during WR produces no write, and the in-flight request is dropped with no response.
- `mem_addr` and `mem_wdata` are held from the latches between requests. They change only on acceptance.

## Structure
- Package `rv64_mem_pkg` contains:
  - `mem_funct3_e`, the funct3 encodings.
  - `lsu_state_e`, {IDLE, RD, WR, RESP}.
  - A size-in-bytes function from funct3.
- Sub-module `lsu_align` is combinational. Inputs: window, wdata, funct3. Outputs: the extended load value and the merged store window.
- `lsu_mem_port` holds the FSM, the latches and the error check.

## Test plan
Bench instantiates `lsu_mem_port` with the RAM (N=13, M=64). Before each scenario it preloads bytes 0x1000..0x1007 = 11 22 33 44 55 66 77 88.
- LD 0x1000 → `resp_rdata` = 0x8877665544332211, `resp_valid` in the cycle after edge T+2, `mem_we` never high.
- LB 0x1007 → 0xFFFFFFFFFFFFFF88; LBU 0x1007 → 0x0000000000000088; LW 0x1004 → 0xFFFFFFFF88776655.
- SH wdata 0x…ABCD to 0x1002 → bytes 0x1002=CD and 0x1003=AB; bytes 0x1000/01 and 0x1004..0x1009 unchanged; `mem_we` high exactly 1 cycle; `resp_rdata`=0.
- LW 0x1FFE, LD 0x2000, and funct3=111 load → `resp_err=1` in the cycle after edge T+1, `resp_rdata=0`, no `mem_we`, RAM unchanged.
- SD 0xDEADBEEF00C0FFEE to 0x1000 with `rst` pulsed in the WR cycle → `mem_we` stays 0, memory still 11..88, no `resp_valid`, `req_ready=1` after reset.
- SD 0xDEADBEEF00C0FFEE to 0x1000, then LD 0x1000 accepted in the SD's RESP cycle → load returns 0xDEADBEEF00C0FFEE two cycles later.
